// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
//
// Purpose:
//   Front end of the pipeline. Owns the fetch PC, issues in-order requests to
//   a variable-latency instruction memory, buffers returned instructions in a
//   DEPTH-entry queue and hands them to decode. After a jump redirect, the
//   queue is flushed and every response still in flight is discarded.
//
// Parameters:
//   RESET_PC : PC of the first fetch after reset.
//   DEPTH    : queue entries and maximum outstanding requests (power of 2, >= 2).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset.
//   imem_req_valid    : out, fetch request this cycle.
//   imem_req_addr     : out, request address (word aligned).
//   imem_req_ready    : in,  memory accepts the request.
//   imem_resp_valid   : in,  in-order response for the oldest outstanding request.
//   imem_resp_data    : in,  returned instruction word.
//   can_jump, jump_pc : in,  redirect (flush) from a later stage and its target.
//   d_allow_in        : in,  decode can accept.
//   f_to_d_valid      : out, queue head valid for decode.
//   F_pc, f_instr     : out, PC / instruction of the queue head (0 while empty).
//   f_default_pc      : out, F_pc + 4 (0 while empty).
//
// Handshakes: a transfer happens on a cycle where valid and ready (or
// allow_in) are both high at the rising edge of clk. A producer holding valid
// keeps its payload stable until the transfer; the consumer may change its
// ready at any time.
//
// Optional feature (macro FETCH_BYPASS_EN): when the queue is empty and a live
// response arrives, it is presented to decode in the same cycle and, if decode
// accepts it, never enters the queue. Without the macro every response is
// queued first and is visible the cycle after it returns.
// ---------------------------------------------------------------------------
module fetch_queue_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        can_jump,
    input  logic [31:0] jump_pc,
    input  logic        d_allow_in,
    output logic        f_to_d_valid,
    output logic [31:0] F_pc,
    output logic [31:0] f_instr,
    output logic [31:0] f_default_pc
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Architectural state
    logic [31:0]   r_pc;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;

    // PCs of issued requests, oldest at r_if_head; popped by every response,
    // including the ones being discarded, so it stays aligned with memory.
    logic [31:0]   r_if_pc [DEPTH];
    logic [PW-1:0] r_if_head;
    logic [PW-1:0] r_if_tail;

    logic          w_empty;
    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_resp_live;
    logic [31:0]   w_resp_pc;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_after_resp;
    logic          w_unused_jump_lsbs;

    assign w_empty     = (r_count == '0);
    assign w_occ       = {1'b0, r_count} + {1'b0, r_out};
    assign w_resp_live = imem_resp_valid & (r_drop == '0);
    assign w_resp_pc   = r_if_pc[r_if_head];

    // Queue plus in-flight never exceeds DEPTH, so a push can never hit a
    // full queue and the in-flight PC FIFO can never overflow.
    assign imem_req_valid = ~rst & ~can_jump & (w_occ < DEPTH_W);
    assign imem_req_addr  = r_pc;
    assign w_issue        = imem_req_valid & imem_req_ready;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty & w_resp_live & ~can_jump;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypass_take = w_bypass & d_allow_in;
    assign f_to_d_valid  = (~w_empty | w_bypass) & ~can_jump;
    assign w_pop         = ~w_empty & ~can_jump & d_allow_in;
    assign w_push        = w_resp_live & ~can_jump & ~w_bypass_take;

    // No issue is possible during a redirect, so only the response matters.
    assign w_out_after_resp = r_out - CW'(imem_resp_valid);

    // Redirect targets are forced word aligned.
    assign w_unused_jump_lsbs = &jump_pc[1:0];

    // Head presentation; all zero while nothing is available.
    always_comb begin
        F_pc         = '0;
        f_instr      = '0;
        f_default_pc = '0;
        if (w_bypass) begin
            F_pc    = w_resp_pc;
            f_instr = imem_resp_data;
        end else if (!w_empty) begin
            F_pc    = r_q_pc[r_head];
            f_instr = r_q_instr[r_head];
        end
        if (w_bypass || !w_empty) begin
            f_default_pc = F_pc + 32'd4;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_out     <= '0;
            r_drop    <= '0;
            r_if_head <= '0;
            r_if_tail <= '0;
        end else if (can_jump) begin
            r_pc    <= {jump_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= w_out_after_resp;
            // Everything still in flight after this cycle is stale.
            r_drop  <= w_out_after_resp;
            if (imem_resp_valid) begin
                r_if_head <= r_if_head + PW'(1);
            end
        end else begin
            if (w_issue) begin
                r_pc      <= r_pc + 32'd4;
                r_if_tail <= r_if_tail + PW'(1);
            end
            if (imem_resp_valid) begin
                r_if_head <= r_if_head + PW'(1);
                if (r_drop != '0) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
            r_out <= r_out + CW'(w_issue) - CW'(imem_resp_valid);
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_if_pc[r_if_tail] <= r_pc;
        end
        if (w_push) begin
            r_q_pc[r_tail]    <= w_resp_pc;
            r_q_instr[r_tail] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_stage
//
// Self-checking bench for fetch_queue_stage. A memory model answers requests
// in order after a programmable latency; a program-order reference (next PC,
// list of live fetched instructions, stale in-flight count) predicts what
// decode must see. A monitor pops the expected queue whenever decode takes an
// instruction.
// ---------------------------------------------------------------------------
module tb_fetch_queue_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
    localparam int          FILL     = 1;
`else
    localparam int          FILL     = 2;
`endif

    logic        clk             = 1'b0;
    logic        rst             = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready  = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'd0;
    logic        can_jump        = 1'b0;
    logic [31:0] jump_pc         = 32'd0;
    logic        d_allow_in      = 1'b1;
    logic        f_to_d_valid;
    logic [31:0] F_pc;
    logic [31:0] f_instr;
    logic [31:0] f_default_pc;

    fetch_queue_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .can_jump        (can_jump),
        .jump_pc         (jump_pc),
        .d_allow_in      (d_allow_in),
        .f_to_d_valid    (f_to_d_valid),
        .F_pc            (F_pc),
        .f_instr         (f_instr),
        .f_default_pc    (f_default_pc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];          // {pc, instr} in program order, live only
    logic [31:0] mem_addr_q[$];     // memory model: pending requests
    int          mem_ready_q[$];    // cycle in which each response is due
    bit          mem_stale_q[$];    // issued before the latest redirect
    logic [31:0] model_pc = RESET_PC;
    int          cyc      = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          popped   = 1'b0;   // decode took an instruction this cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // ---------------- reference model + memory ----------------
    initial begin : ref_model
        int stale_n;
        int occ;
        forever begin
            @(posedge clk);
            if (rst) begin
                mem_addr_q.delete();
                mem_ready_q.delete();
                mem_stale_q.delete();
                exp_q.delete();
                model_pc = RESET_PC;
                popped   = 1'b0;
            end else begin
                stale_n = 0;
                foreach (mem_stale_q[i]) if (mem_stale_q[i]) stale_n++;
                // Instructions held for decode or in flight at the start of
                // this cycle, stale ones included.
                occ = exp_q.size() + stale_n + (popped ? 1 : 0);
                chk("req_valid", 32'(imem_req_valid), 32'(!can_jump && occ < DEPTH));
                if (imem_resp_valid) begin
                    void'(mem_addr_q.pop_front());
                    void'(mem_ready_q.pop_front());
                    void'(mem_stale_q.pop_front());
                end
                if (can_jump) begin
                    exp_q.delete();
                    foreach (mem_stale_q[i]) mem_stale_q[i] = 1'b1;
                    model_pc = {jump_pc[31:2], 2'b00};
                end else if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_req_addr, model_pc);
                    mem_addr_q.push_back(imem_req_addr);
                    mem_ready_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                    mem_stale_q.push_back(1'b0);
                    exp_q.push_back({model_pc, instr_of(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                popped = 1'b0;
            end
            cyc++;
            #1;
            if (mem_ready_q.size() != 0 && mem_ready_q[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mem_addr_q[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (can_jump) chk("valid_during_jump", 32'(f_to_d_valid), 32'd0);
                if (f_to_d_valid && d_allow_in) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_delivery: got F_pc=%h, required no delivery", F_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("f_pc", F_pc, e[63:32]);
                        chk("f_instr", f_instr, e[31:0]);
                        chk("f_default_pc", f_default_pc, e[63:32] + 32'd4);
                    end
                    popped = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (f_to_d_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (imem_req_valid) ok = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bit          ok;
        int          fill;
        int          delivered;
        logic [63:0] head_e;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_f_valid", 32'(f_to_d_valid), 32'd0);
        chk("rst_f_pc", F_pc, 32'd0);
        chk("rst_f_instr", f_instr, 32'd0);
        chk("rst_f_default_pc", f_default_pc, 32'd0);

        // Fill latency and streaming throughput with a 1-cycle memory
        step();
        rst = 1'b0;
        fill = 0;
        ok   = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clk);
            if (f_to_d_valid) ok = 1'b1;
            else fill++;
        end
        chk("first_valid_seen", 32'(ok), 32'd1);
        chk("fill_cycles", 32'(fill), 32'(FILL));
        chk("first_f_pc", F_pc, RESET_PC);
        chk("first_default_pc", f_default_pc, RESET_PC + 32'd4);
        delivered = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_to_d_valid && d_allow_in) delivered++;
        end
        chk("throughput", 32'(delivered), 32'd20);

        // Decode stall: request issue must stop once queue + in-flight is full
        step();
        d_allow_in = 1'b0;
        repeat (10) step();
        @(negedge clk);
        head_e = (exp_q.size() != 0) ? exp_q[0] : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_f_valid", 32'(f_to_d_valid), 32'd1);
        chk("stall_head_pc", F_pc, head_e[63:32]);
        step();
        d_allow_in = 1'b1;
        repeat (10) step();

        // Redirect with 3-cycle memory and requests in flight
        lat_min = 3;
        lat_max = 3;
        repeat (12) step();
        can_jump = 1'b1;
        jump_pc  = 32'h8000_0102;
        @(negedge clk);
        chk("jump_f_valid", 32'(f_to_d_valid), 32'd0);
        chk("jump_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        can_jump = 1'b0;
        wait_req(8, ok);
        chk("redirect_req_seen", 32'(ok), 32'd1);
        chk("redirect_req_addr", imem_req_addr, 32'h8000_0100);
        wait_valid(20, ok);
        chk("redirect_deliver_seen", 32'(ok), 32'd1);
        chk("redirect_first_pc", F_pc, 32'h8000_0100);

        // Back-to-back redirects with a 2-cycle memory
        step();
        lat_min = 2;
        lat_max = 2;
        repeat (8) step();
        can_jump = 1'b1;
        jump_pc  = 32'h8000_0200;
        step();
        jump_pc  = 32'h8000_0300;
        step();
        can_jump = 1'b0;
        wait_valid(20, ok);
        chk("b2b_deliver_seen", 32'(ok), 32'd1);
        chk("b2b_first_pc", F_pc, 32'h8000_0300);

        // PC wrap at 2^32
        step();
        lat_min  = 1;
        lat_max  = 1;
        can_jump = 1'b1;
        jump_pc  = 32'hFFFF_FFFC;
        step();
        can_jump = 1'b0;
        wait_valid(20, ok);
        chk("wrap_deliver_seen", 32'(ok), 32'd1);
        chk("wrap_f_pc", F_pc, 32'hFFFF_FFFC);
        chk("wrap_default_pc", f_default_pc, 32'd0);
        wait_valid(20, ok);
        chk("wrap_next_seen", 32'(ok), 32'd1);
        chk("wrap_next_pc", F_pc, 32'd0);

        // Randomized traffic, including one mid-run reset
        step();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            step();
            rst            = (i == 400 || i == 401);
            d_allow_in     = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            can_jump       = ($urandom_range(0, 15) == 0);
            jump_pc        = $urandom;
        end

        // Drain: stop issuing and let every live instruction reach decode
        step();
        rst            = 1'b0;
        can_jump       = 1'b0;
        d_allow_in     = 1'b1;
        imem_req_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && mem_addr_q.size() == 0) ok = 1'b1;
        end
        chk("drain_done", 32'(ok), 32'd1);
        @(negedge clk);
        chk("drain_f_valid", 32'(f_to_d_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
